// File: rtl/engine_csr.sv
// Wishbone control/status register block for the Levenshtein engine.
// Owns enable, word length, start command, done/error flags, result capture and interrupt.
module engine_csr #(
  parameter int DATA_WIDTH   = 8,
  parameter int LENGTH_WIDTH = 5,
  parameter int MAX_LENGTH   = 2**LENGTH_WIDTH-1,
  parameter int RESULT_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  input  logic [1:0]              adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    enabled_o,
  output logic [LENGTH_WIDTH-1:0] word_length_o,
  output logic                    start_o,
  input  logic                    busy_i,
  input  logic                    done_i,
  input  logic [RESULT_WIDTH-1:0] result_i,
  output logic                    irq_o
);

  localparam logic [1:0] ADR_CTRL   = 2'd0;
  localparam logic [1:0] ADR_CMD    = 2'd1;
  localparam logic [1:0] ADR_RESULT = 2'd2;
  localparam logic [1:0] ADR_RSVD   = 2'd3;
  localparam logic [LENGTH_WIDTH-1:0] MAX_LEN = LENGTH_WIDTH'(MAX_LENGTH);

  logic                    req;
  logic                    ctrl_wr;
  logic                    cmd_wr;
  logic                    start_ok;
  logic                    enable_q;
  logic                    irq_en_q;
  logic                    done_q;
  logic                    start_err_q;
  logic [LENGTH_WIDTH-1:0] word_length_q;
  logic [LENGTH_WIDTH-1:0] len_sat;
  logic [RESULT_WIDTH-1:0] result_q;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    unused_dat;

  // A request is taken only while no response is outstanding, so a held strobe is not re-accepted.
  assign req      = cyc_i & stb_i & ~ack_o & ~err_o;
  assign ctrl_wr  = req & we_i & (adr_i == ADR_CTRL);
  assign cmd_wr   = req & we_i & (adr_i == ADR_CMD);
  assign start_ok = enable_q & ~busy_i & ~start_o;
  assign len_sat  = (dat_i[LENGTH_WIDTH-1:0] > MAX_LEN) ? MAX_LEN : dat_i[LENGTH_WIDTH-1:0];
  assign unused_dat = ^dat_i;

  always_comb begin
    rd_data = '0;
    case (adr_i)
      ADR_CTRL: begin
        rd_data[DATA_WIDTH-1]     = enable_q;
        rd_data[DATA_WIDTH-2]     = irq_en_q;
        rd_data[LENGTH_WIDTH-1:0] = word_length_q;
      end
      ADR_CMD: begin
        rd_data[0] = busy_i | start_o;
        rd_data[1] = done_q;
        rd_data[2] = start_err_q;
      end
      ADR_RESULT: rd_data[RESULT_WIDTH-1:0] = result_q;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= req & (adr_i != ADR_RSVD);
      err_o <= req & (adr_i == ADR_RSVD);
      if (req && !we_i) dat_o <= rd_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      enable_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      word_length_q <= '0;
    end else if (ctrl_wr) begin
      enable_q      <= dat_i[DATA_WIDTH-1];
      irq_en_q      <= dat_i[DATA_WIDTH-2];
      word_length_q <= len_sat;
    end
  end

  // Set conditions take priority over the W1C clears on the same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      start_o     <= 1'b0;
      start_err_q <= 1'b0;
      done_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      start_o <= cmd_wr & dat_i[0] & start_ok;
      if (cmd_wr && dat_i[0] && !start_ok) start_err_q <= 1'b1;
      else if (cmd_wr && dat_i[2])         start_err_q <= 1'b0;
      if (done_i)                  done_q <= 1'b1;
      else if (cmd_wr && dat_i[1]) done_q <= 1'b0;
      if (done_i) result_q <= result_i;
    end
  end

  assign rty_o         = 1'b0;
  assign enabled_o     = enable_q;
  assign word_length_o = word_length_q;
  assign irq_o         = irq_en_q & done_q;

endmodule

// File: tb/tb_engine_csr.sv
// Self-checking bench for engine_csr: directed register-map cases plus randomized bus traffic
// against a transaction-level model, compared on every cycle.
module tb_engine_csr;

  localparam int DW   = 8;
  localparam int LW   = 5;
  localparam int MAXL = 20;
  localparam int RW   = 8;

  logic          clk_i;
  logic          rst_n;
  logic          cyc_i, stb_i, we_i;
  logic [1:0]    adr_i;
  logic [DW-1:0] dat_i;
  logic          ack_o, err_o, rty_o;
  logic [DW-1:0] dat_o;
  logic          enabled_o;
  logic [LW-1:0] word_length_o;
  logic          start_o;
  logic          busy_i, done_i;
  logic [RW-1:0] result_i;
  logic          irq_o;

  int n_chk  = 0;
  int n_fail = 0;
  bit auto_eng = 0;
  int eng_cnt = 0;

  engine_csr #(.DATA_WIDTH(DW), .LENGTH_WIDTH(LW), .MAX_LENGTH(MAXL), .RESULT_WIDTH(RW)) dut (
    .clk_i(clk_i), .rst_ni(rst_n), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .ack_o(ack_o), .err_o(err_o), .rty_o(rty_o),
    .dat_o(dat_o), .enabled_o(enabled_o), .word_length_o(word_length_o),
    .start_o(start_o), .busy_i(busy_i), .done_i(done_i), .result_i(result_i),
    .irq_o(irq_o)
  );

  initial begin
    clk_i = 0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: register map state, advanced once per clock from the bench's own inputs.
  bit       m_ack = 0, m_err = 0, m_start = 0;
  bit       m_en = 0, m_ie = 0, m_done = 0, m_se = 0;
  int       m_wl = 0;
  logic [7:0] m_res = 0, m_dat = 0;

  always @(posedge clk_i or negedge rst_n) begin
    bit acc, n_ack, n_err, n_start, set_se;
    int len;
    if (!rst_n) begin
      m_ack = 0; m_err = 0; m_start = 0; m_en = 0; m_ie = 0;
      m_done = 0; m_se = 0; m_wl = 0; m_res = 0; m_dat = 0;
    end else begin
      acc = cyc_i && stb_i && !m_ack && !m_err;
      n_ack = 0; n_err = 0; n_start = 0; set_se = 0;
      if (acc) begin
        if (adr_i == 3) begin
          n_err = 1;
          if (!we_i) m_dat = 0;
        end else begin
          n_ack = 1;
          if (!we_i) begin
            case (adr_i)
              0: m_dat = 8'((m_en ? 128 : 0) + (m_ie ? 64 : 0) + m_wl);
              1: m_dat = 8'(((busy_i || m_start) ? 1 : 0) + (m_done ? 2 : 0) + (m_se ? 4 : 0));
              default: m_dat = m_res;
            endcase
          end else if (adr_i == 0) begin
            m_en = dat_i[7];
            m_ie = dat_i[6];
            len  = int'(dat_i) % 32;
            m_wl = (len > MAXL) ? MAXL : len;
          end else if (adr_i == 1) begin
            if (dat_i[1]) m_done = 0;
            if (dat_i[2]) m_se = 0;
            if (dat_i[0]) begin
              if (m_en && !busy_i && !m_start) n_start = 1;
              else set_se = 1;
            end
          end
        end
      end
      if (set_se) m_se = 1;
      if (done_i) begin
        m_done = 1;
        m_res  = result_i;
      end
      m_ack = n_ack; m_err = n_err; m_start = n_start;
    end
  end

  always @(negedge clk_i) begin
    chk("ack_o", ack_o, m_ack);
    chk("err_o", err_o, m_err);
    chk("rty_o", rty_o, 0);
    chk("start_o", start_o, m_start);
    chk("dat_o", dat_o, m_dat);
    chk("enabled_o", enabled_o, m_en);
    chk("word_length_o", word_length_o, m_wl);
    chk("irq_o", irq_o, m_ie && m_done);
  end

  // One clock; inputs change 1 time unit after the edge. Optionally behaves as the engine.
  task automatic tick();
    logic st;
    st = start_o;
    @(posedge clk_i);
    #1;
    if (auto_eng) begin
      done_i = 0;
      if (busy_i) begin
        eng_cnt--;
        if (eng_cnt <= 0) begin
          busy_i   = 0;
          done_i   = 1;
          result_i = 8'($urandom);
        end
      end else if (st) begin
        busy_i  = 1;
        eng_cnt = $urandom_range(1, 5);
      end else if ($urandom_range(0, 15) == 0) begin
        done_i   = 1;
        result_i = 8'($urandom);
      end
    end
  endtask

  task automatic bus(input logic we, input logic [1:0] adr, input logic [7:0] dat,
                     input logic hold, input logic dpulse, input logic [7:0] dres,
                     output logic [7:0] rd, output logic acked, output logic erred,
                     output logic st);
    cyc_i = 1; stb_i = 1; we_i = we; adr_i = adr; dat_i = dat;
    if (dpulse) begin
      done_i = 1;
      result_i = dres;
    end
    tick();
    if (dpulse) done_i = 0;
    acked = ack_o; erred = err_o; rd = dat_o; st = start_o;
    chk("bus_resp", acked | erred, 1);
    if (hold) tick();
    cyc_i = 0; stb_i = 0; we_i = 0;
    tick();
  endtask

  task automatic wr(input logic [1:0] adr, input logic [7:0] dat, output logic st);
    logic [7:0] rd;
    logic a, e;
    bus(1, adr, dat, 0, 0, 0, rd, a, e, st);
  endtask

  task automatic rd_chk(input string nm, input logic [1:0] adr, input logic [7:0] exp);
    logic [7:0] rd;
    logic a, e, st;
    bus(0, adr, 0, 0, 0, 0, rd, a, e, st);
    chk(nm, rd, exp);
  endtask

  initial begin
    logic [7:0] rd;
    logic a, e, st;
    rst_n = 1; cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0;
    busy_i = 0; done_i = 0; result_i = 0;
    #1 rst_n = 0;
    repeat (3) @(posedge clk_i);
    #3 rst_n = 1;
    tick();
    chk("rst_ack", ack_o, 0);
    chk("rst_enabled", enabled_o, 0);
    chk("rst_irq", irq_o, 0);

    bus(0, 0, 0, 0, 0, 0, rd, a, e, st);
    chk("rd_ctrl_rst", rd, 8'h00);
    chk("rd_ctrl_ack", a, 1);
    bus(0, 3, 0, 0, 0, 0, rd, a, e, st);
    chk("rsvd_err", e, 1);
    chk("rsvd_noack", a, 0);
    chk("rsvd_dat", rd, 8'h00);

    wr(0, 8'hDF, st);
    chk("en_after_df", enabled_o, 1);
    chk("wl_sat_df", word_length_o, 20);
    rd_chk("ctrl_df", 0, 8'hD4);
    wr(0, 8'h9F, st);
    rd_chk("ctrl_9f", 0, 8'h94);
    wr(0, 8'hDF, st);

    wr(1, 8'h01, st);
    chk("start_pulse", st, 1);
    chk("start_one_cycle", start_o, 0);
    busy_i = 1;
    wr(1, 8'h01, st);
    chk("start_busy_blocked", st, 0);
    rd_chk("status_busy_err", 1, 8'h05);
    wr(1, 8'h04, st);
    rd_chk("status_err_clr", 1, 8'h01);
    busy_i = 0;

    done_i = 1; result_i = 8'h2A;
    tick();
    done_i = 0;
    chk("irq_on_done", irq_o, 1);
    rd_chk("status_done", 1, 8'h02);
    rd_chk("result_2a", 2, 8'h2A);
    wr(1, 8'h02, st);
    chk("irq_cleared", irq_o, 0);

    done_i = 1; result_i = 8'h11;
    tick();
    done_i = 0;
    bus(1, 1, 8'h02, 0, 1, 8'h07, rd, a, e, st);
    rd_chk("done_set_wins", 1, 8'h02);
    rd_chk("result_07", 2, 8'h07);
    wr(2, 8'hFF, st);
    rd_chk("result_ro", 2, 8'h07);

    wr(1, 8'h02, st);
    bus(0, 1, 0, 1, 1, 8'h33, rd, a, e, st);
    chk("status_pre_edge", rd, 8'h00);
    rd_chk("status_post_done", 1, 8'h02);

    wr(0, 8'h00, st);
    wr(1, 8'h01, st);
    chk("start_disabled", st, 0);
    rd_chk("status_disabled", 1, 8'h06);
    wr(1, 8'h05, st);
    rd_chk("serr_set_wins", 1, 8'h06);

    auto_eng = 1;
    for (int i = 0; i < 500; i++) begin
      logic [1:0] ad;
      logic [7:0] dv;
      ad = 2'($urandom);
      dv = 8'($urandom);
      if (ad == 1 && $urandom_range(0, 1) == 1) dv[2:1] = 2'b00;
      bus(1'($urandom), ad, dv, 1'($urandom), 0, 0, rd, a, e, st);
      repeat ($urandom_range(0, 2)) tick();
    end
    auto_eng = 0;
    busy_i = 0; done_i = 0;
    tick();

    wr(0, 8'hDF, st);
    done_i = 1; result_i = 8'h5A;
    tick();
    done_i = 0;
    cyc_i = 1; stb_i = 1; we_i = 1; adr_i = 1; dat_i = 8'h01;
    tick();
    chk("mid_ack", ack_o, 1);
    chk("mid_start", start_o, 1);
    chk("mid_irq", irq_o, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_async_ack", ack_o, 0);
    chk("rst_async_start", start_o, 0);
    chk("rst_async_irq", irq_o, 0);
    chk("rst_async_en", enabled_o, 0);
    cyc_i = 0; stb_i = 0; we_i = 0;
    @(posedge clk_i);
    #3 rst_n = 1;
    tick();
    rd_chk("status_after_rst", 1, 8'h00);
    rd_chk("result_after_rst", 2, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
